// File: rtl/glyph_plotter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | glyph_plotter                                                            |
// | Renders 8x8 font glyphs on a 40x30 text grid as one VGA pixel per cycle. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module glyph_plotter #(
  parameter int         COLS      = 40,
  parameter int         ROWS      = 30,
  parameter logic [2:0] BG_COLOUR = 3'b111
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] char,
  input  logic [2:0] char_fg,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [9:0] font_addr,
  input  logic [7:0] font_row,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_FETCH   = 3'd1;
  localparam logic [2:0] c_S_LATCH   = 3'd2;
  localparam logic [2:0] c_S_PLOT    = 3'd3;
  localparam logic [2:0] c_S_ADVANCE = 3'd4;
  localparam logic [2:0] c_S_NEWLINE = 3'd5;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [5:0] r_col;
  logic [4:0] r_row;
  logic [2:0] r_glyph_row;
  logic [2:0] r_px;
  logic [6:0] r_char;
  logic [2:0] r_fg;
  logic [7:0] r_row_bits;
  logic [8:0] r_x_hold;
  logic [7:0] r_y_hold;
  logic [2:0] r_colour_hold;

  logic       w_is_nl;
  logic       w_is_cr;
  logic       w_printable;
  logic [6:0] w_code_eff;
  logic [4:0] w_row_inc;
  logic [8:0] w_x;
  logic [7:0] w_y;
  logic [2:0] w_colour;

  assign w_is_nl     = (char == 8'h0A);
  assign w_is_cr     = (char == 8'h0D);
  assign w_printable = (char >= 8'h20) && (char < 8'h7F);
  assign w_code_eff  = w_printable ? char[6:0] : 7'h20;
  assign w_row_inc   = (r_row == 5'(ROWS - 1)) ? 5'd0 : r_row + 5'd1;

  // Cell origins are multiples of 8, so concatenation replaces the adders.
  assign w_x      = {r_col, r_px};
  assign w_y      = {r_row, r_glyph_row};
  assign w_colour = r_row_bits[3'd7 - r_px] ? r_fg : BG_COLOUR;

  assign font_addr = {r_char, r_glyph_row};

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= c_S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (char_valid) begin
          if (w_is_nl)       w_state_nxt = c_S_NEWLINE;
          else if (!w_is_cr) w_state_nxt = c_S_FETCH;
        end
      end
      c_S_FETCH: w_state_nxt = c_S_LATCH;
      c_S_LATCH: w_state_nxt = c_S_PLOT;
      c_S_PLOT: begin
        if (r_px == 3'd7)
          w_state_nxt = (r_glyph_row == 3'd7) ? c_S_ADVANCE : c_S_FETCH;
      end
      c_S_ADVANCE: w_state_nxt = c_S_IDLE;
      c_S_NEWLINE: w_state_nxt = c_S_IDLE;
      default:     w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    char_ready = 1'b0;
    plot       = 1'b0;
    x          = r_x_hold;
    y          = r_y_hold;
    colour     = r_colour_hold;
    case (r_state)
      c_S_IDLE: char_ready = 1'b1;
      c_S_PLOT: begin
        plot   = 1'b1;
        x      = w_x;
        y      = w_y;
        colour = w_colour;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_col         <= '0;
      r_row         <= '0;
      r_glyph_row   <= '0;
      r_px          <= '0;
      r_char        <= '0;
      r_fg          <= '0;
      r_row_bits    <= '0;
      r_x_hold      <= '0;
      r_y_hold      <= '0;
      r_colour_hold <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (char_valid) begin
            r_char <= w_code_eff;
            r_fg   <= char_fg;
          end
        end
        c_S_LATCH: begin
          r_row_bits <= font_row;
          r_px       <= 3'd0;
        end
        c_S_PLOT: begin
          r_px          <= r_px + 3'd1;
          r_x_hold      <= w_x;
          r_y_hold      <= w_y;
          r_colour_hold <= w_colour;
          if (r_px == 3'd7 && r_glyph_row != 3'd7)
            r_glyph_row <= r_glyph_row + 3'd1;
        end
        c_S_ADVANCE: begin
          r_glyph_row <= 3'd0;
          if (r_col == 6'(COLS - 1)) begin
            r_col <= 6'd0;
            r_row <= w_row_inc;
          end else begin
            r_col <= r_col + 6'd1;
          end
        end
        c_S_NEWLINE: begin
          r_col <= 6'd0;
          r_row <= w_row_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glyph_plotter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_glyph_plotter                                                         |
// | Directed self-checking bench for glyph_plotter with a 1-cycle font ROM.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_glyph_plotter;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] char;
  logic [2:0] char_fg;
  logic       char_valid;
  logic       char_ready;
  logic [9:0] font_addr;
  logic [7:0] font_row;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;

  glyph_plotter dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .char       (char),
    .char_fg    (char_fg),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .font_addr  (font_addr),
    .font_row   (font_row),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  typedef struct {int cyc; int x; int y; int c; int fa;} px_t;
  px_t q[$];
  int  cyc = 0;
  int  n_pass = 0;
  int  n_fail = 0;
  int  n_total = 0;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Font: space is blank, every other glyph row is 8'b10000001.
  always @(posedge CLOCK_50)
    font_row <= (font_addr[9:3] == 7'h20) ? 8'h00 : 8'h81;

  always @(negedge CLOCK_50)
    if (plot === 1'b1)
      q.push_back('{cyc, int'(x), int'(y), int'(colour), int'(font_addr)});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] code, input logic [2:0] fg, output int acc);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    char = code; char_fg = fg; char_valid = 1'b1;
    while (char_ready !== 1'b1 && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (char_ready !== 1'b1) chk("send_timeout", 0, 1);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    acc = cyc;
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int c);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (char_ready !== 1'b1 && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (char_ready !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    c = cyc;
  endtask

  task automatic check_glyph(input string tag, input int acc, input int x0, input int y0,
                             input int fg, input int bits, input int base, input int rdy);
    int bad, ec, r, p;
    bad = 0;
    chk({tag, "_count"}, q.size(), 64);
    for (int i = 0; i < q.size() && i < 64; i++) begin
      r  = i / 8;
      p  = i % 8;
      ec = ((bits >> (7 - p)) & 1) != 0 ? fg : 7;
      if (q[i].cyc != acc + 2 + r * 10 + p || q[i].x != x0 + p || q[i].y != y0 + r ||
          q[i].c != ec || q[i].fa != base + r)
        bad++;
    end
    chk({tag, "_pixels"}, bad, 0);
    chk({tag, "_ready"}, rdy, acc + 81);
  endtask

  task automatic glyph(input string tag, input logic [7:0] code, input logic [2:0] fg,
                       input int x0, input int y0);
    int acc, rdy, eff;
    eff = (code < 8'h20 || code >= 8'h7F) ? 32'h20 : int'(code);
    q.delete();
    send(code, fg, acc);
    wait_ready(tag, rdy);
    check_glyph(tag, acc, x0, y0, int'(fg), (eff == 32'h20) ? 0 : 32'h81, eff * 8, rdy);
  endtask

  task automatic newline(input string tag, input bit check);
    int acc, rdy;
    send(8'h0A, 3'b000, acc);
    wait_ready(tag, rdy);
    if (check) chk({tag, "_ready"}, rdy, acc + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rdy, bad, n;
    reset = 1'b1; char = 8'h00; char_fg = 3'b000; char_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;

    // Reset state and idle
    @(negedge CLOCK_50);
    chk("rst_ready", char_ready, 1);
    chk("rst_plot", plot, 0);
    chk("rst_colour", colour, 0);
    chk("rst_font_addr", font_addr, 0);
    q.delete();
    bad = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (char_ready !== 1'b1 || plot !== 1'b0) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    chk("idle_plots", q.size(), 0);
    chk("idle_x", x, 0);
    chk("idle_y", y, 0);

    // Single glyph, then B at col 1, CR, newline, C on row 1
    glyph("A", 8'h41, 3'b100, 0, 0);
    glyph("B", 8'h42, 3'b010, 8, 0);
    q.delete();
    send(8'h0D, 3'b000, acc);
    repeat (15) @(negedge CLOCK_50);
    chk("cr_plots", q.size(), 0);
    chk("cr_ready", char_ready, 1);
    newline("nl", 1'b1);
    glyph("C", 8'h43, 3'b001, 0, 8);

    // Line wrap
    do_reset();
    for (int i = 0; i < 40; i++)
      glyph($sformatf("wrap%0d", i), 8'h61 + 8'(i % 26), 3'(i % 8), i * 8, 0);
    glyph("wrap41", 8'h5A, 3'b011, 0, 8);

    // Screen wrap: cursor now row 1; 28 newlines reach row 29, one more wraps
    for (int i = 0; i < 28; i++) newline("nl_loop", 1'b0);
    newline("nl_wrap", 1'b1);
    glyph("D", 8'h44, 3'b101, 0, 0);

    // Busy: held valid is consumed only when ready again
    do_reset();
    q.delete();
    @(negedge CLOCK_50);
    char = 8'h45; char_fg = 3'b011; char_valid = 1'b1;
    n = 0;
    while (q.size() < 65 && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    char_valid = 1'b0;
    wait_ready("busy", rdy);
    chk("busy_count", q.size(), 128);
    if (q.size() >= 65) begin
      chk("busy_gap", q[64].cyc - q[0].cyc, 82);
      chk("busy_row_span", q[63].cyc - q[0].cyc, 77);
      chk("busy_x2", q[64].x, 8);
    end

    // Illegal code renders as a blank space glyph
    glyph("bel", 8'h07, 3'b010, 16, 0);

    // Reset at the 10th plot of a glyph
    q.delete();
    send(8'h46, 3'b101, acc);
    while (cyc < acc + 13) @(negedge CLOCK_50);
    chk("mid_plot_before", plot, 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("mid_plot_after", plot, 0);
    chk("mid_ready_after", char_ready, 1);
    reset = 1'b0;
    chk("mid_count", q.size(), 10);
    repeat (20) @(negedge CLOCK_50);
    chk("mid_no_more", q.size(), 10);
    glyph("G_after_rst", 8'h47, 3'b110, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
